rmw_ctrl: RTL and testbench

RMW_CTRL -- requirements
Module: rmw_ctrl

---
 rtl/rmw_ctrl_if.sv | 25 ++
 rtl/rmw_ctrl.sv | 67 ++++++
 tb/tb_rmw_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rmw_ctrl_if.sv
// rmw_ctrl_if: control/status bundle between the RMW sequencer and its datapath/bus environment.
interface rmw_ctrl_if;
    logic       RDY;
    logic       start;
    logic [2:0] func;
    logic       C_in;
    logic [2:0] op;
    logic [2:0] sel;
    logic [2:0] op_ld;
    logic       CI;
    logic       WE;
    logic       nz_we;
    logic       c_we;
    logic       busy;
    logic       done;
    logic       err;
    modport slave (
        input  RDY, start, func, C_in,
        output op, sel, op_ld, CI, WE, nz_we, c_we, busy, done, err
    );
    modport master (
        output RDY, start, func, C_in,
        input  op, sel, op_ld, CI, WE, nz_we, c_we, busy, done, err
    );
endinterface

// File: rtl/rmw_ctrl.sv
// rmw_ctrl: read / dummy-rewrite / modified-write sequencer for INC, DEC, ASL, LSR, ROL, ROR on memory.
module rmw_ctrl (
    input logic         clk,
    input logic         reset,
    rmw_ctrl_if.slave   bus
);
    localparam logic [2:0] OP_AI   = 3'd0;
    localparam logic [2:0] OP_ROL  = 3'd1;
    localparam logic [2:0] OP_ROR  = 3'd2;
    localparam logic [2:0] OP_ADC  = 3'd6;
    localparam logic [2:0] SEL_0   = 3'd0;
    localparam logic [2:0] SEL_MEM = 3'd1;
    typedef enum logic [2:0] {IDLE, READ, DUMMY, WRITE, DONE} state_t;
    state_t     state_q, state_d;
    logic [2:0] func_q, func_d;
    logic       err_q, err_d;
    logic       wr, mem_phase;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            func_q  <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            err_q   <= err_d;
        end
    end
    // Everything, including the err pulse, only advances while RDY is high.
    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        err_d   = err_q;
        if (bus.RDY) begin
            err_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && bus.func <= 3'd5) begin
                        func_d  = bus.func;
                        state_d = READ;
                    end else if (bus.start) begin
                        err_d = 1'b1;
                    end
                end
                READ:    state_d = DUMMY;
                DUMMY:   state_d = WRITE;
                WRITE:   state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end
    // Func bit patterns: 0/1 use the adder, even shifts go left, odd go right, 4/5 rotate through carry.
    always_comb begin
        wr        = state_q == WRITE;
        mem_phase = state_q == DUMMY || wr;
        bus.op    = !wr ? OP_AI : func_q <= 3'd1 ? OP_ADC : func_q[0] ? OP_ROR : OP_ROL;
        bus.CI    = wr && (func_q == 3'd0 || (func_q[2] && bus.C_in));
        bus.sel   = mem_phase ? SEL_MEM : SEL_0;
        bus.op_ld = mem_phase ? 3'b111 : 3'b011;
        bus.WE    = mem_phase;
        bus.nz_we = wr;
        bus.c_we  = wr && (func_q[2] || func_q[1]);
        bus.busy  = state_q != IDLE;
        bus.done  = state_q == DONE;
        bus.err   = err_q;
    end
endmodule

// File: tb/tb_rmw_ctrl.sv
// tb_rmw_ctrl: directed RMW vectors against a small memory/ALU model; expected bus events go through a scoreboard queue.
module tb_rmw_ctrl;
    logic clk = 1'b0;
    logic reset;
    rmw_ctrl_if bus ();
    rmw_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [15:0] v;
        string       nm;
    } exp_t;
    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mem, m, alu, wr_dat, mem_val;
    logic        co, mem_ld, wr_en, rd_en;
    logic [15:0] act;
    int          lat = 0, work = 0, last_work = 0, done_cnt = 0;
    function automatic logic [15:0] ev(input logic [1:0] t, input logic [7:0] d, input logic [5:0] f);
        return {t, d, f};
    endfunction
    task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask
    task automatic push(input logic [15:0] v, input string nm);
        exp_t e;
        e.v  = v;
        e.nm = nm;
        q.push_back(e);
    endtask
    // ALU model: DEC is taken as M + 8'hFF with carry in 0.
    always_comb begin
        co  = 1'b0;
        alu = bus.sel == 3'd1 ? m : 8'h00;
        if (bus.op == 3'd6) alu = bus.CI ? m + 8'd1 : m - 8'd1;
        else if (bus.op == 3'd1) begin alu = {m[6:0], bus.CI}; co = m[7]; end
        else if (bus.op == 3'd2) begin alu = {bus.CI, m[7:1]}; co = m[0]; end
    end
    always @(posedge clk) begin
        if (mem_ld) mem <= mem_val;
        else if (wr_en) mem <= wr_dat;
        if (rd_en) m <= mem;
    end
    // Monitor: events are {tag, data, nz_we, c_we, CO, CI, N, Z}; tag 1 write, 2 done, 3 err.
    always @(negedge clk) begin
        wr_en    <= bus.RDY && bus.WE && !reset;
        wr_dat   <= alu;
        rd_en    <= bus.RDY && bus.busy && !bus.WE && !bus.done;
        lat      <= bus.busy ? lat + 1 : 0;
        work     <= !bus.busy ? 0 : bus.done ? work : work + 1;
        done_cnt <= done_cnt + int'(bus.RDY && bus.done);
        if (bus.RDY && (bus.WE || bus.done || bus.err)) begin
            act = bus.WE ? ev(2'd1, alu, {bus.nz_we, bus.c_we, bus.c_we & co, bus.CI,
                                         bus.nz_we & alu[7], bus.nz_we & (alu == 8'h00)})
                : bus.done ? ev(2'd2, 8'(lat + 1), 6'd0) : ev(2'd3, 8'h00, 6'd0);
            if (bus.done) last_work <= work;
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got %h expected none", act);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk(e.nm, act, e.v);
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic load(input logic [7:0] v);
        mem_ld  = 1'b1;
        mem_val = v;
        step();
        mem_ld  = 1'b0;
    endtask
    task automatic go(input logic [2:0] f);
        bus.start = 1'b1;
        bus.func  = f;
        step();
        bus.start = 1'b0;
    endtask
    task automatic wait_idle(input string nm);
        for (int k = 0; k < 20 && bus.busy; k++) step();
        chk({nm, "_idle"}, 16'(bus.busy), 16'd0);
    endtask
    task automatic run(input logic [2:0] f, input logic [7:0] mv, input logic cin,
                       input logic [15:0] wexp, input string nm);
        load(mv);
        bus.C_in = cin;
        push(ev(2'd1, mv, 6'd0), {nm, "_dummy"});
        push(wexp, {nm, "_write"});
        push(ev(2'd2, 8'd4, 6'd0), {nm, "_done"});
        go(f);
        wait_idle(nm);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int d0;
        reset = 1'b1; bus.RDY = 1'b1; bus.start = 1'b0; bus.func = 3'd0; bus.C_in = 1'b0;
        mem_ld = 1'b0; mem_val = 8'h00; m = 8'h00;
        #2;
        chk("reset_strobes", 16'({bus.WE, bus.nz_we, bus.c_we, bus.busy, bus.done, bus.err}), 16'd0);
        chk("reset_ctl", 16'({bus.op, bus.sel, bus.op_ld, bus.CI}), 16'({3'd0, 3'd0, 3'b011, 1'b0}));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run(3'd0, 8'h7F, 1'b0, ev(2'd1, 8'h80, 6'b100110), "inc_7f");
        run(3'd1, 8'h00, 1'b1, ev(2'd1, 8'hFF, 6'b100010), "dec_00");
        run(3'd5, 8'h01, 1'b1, ev(2'd1, 8'h80, 6'b111110), "ror_c1");
        run(3'd5, 8'h01, 1'b0, ev(2'd1, 8'h00, 6'b111001), "ror_c0");
        run(3'd2, 8'hC1, 1'b1, ev(2'd1, 8'h82, 6'b111010), "asl_c1");
        run(3'd3, 8'h02, 1'b1, ev(2'd1, 8'h01, 6'b110000), "lsr_02");
        run(3'd4, 8'h80, 1'b1, ev(2'd1, 8'h01, 6'b111100), "rol_80");
        // RDY low for three cycles while in DUMMY
        load(8'h10);
        push(ev(2'd1, 8'h10, 6'd0), "stall_dummy");
        push(ev(2'd1, 8'h11, 6'b100100), "stall_write");
        push(ev(2'd2, 8'd7, 6'd0), "stall_done");
        d0 = done_cnt;
        go(3'd0);
        step();
        bus.RDY = 1'b0;
        repeat (3) begin
            step();
            chk("stall_hold", 16'({bus.WE, bus.nz_we, bus.c_we, bus.busy, bus.sel}), 16'({4'b1001, 3'd1}));
        end
        bus.RDY = 1'b1;
        wait_idle("stall");
        chk("stall_work", 16'(last_work), 16'd6);
        chk("stall_done_cnt", 16'(done_cnt - d0), 16'd1);
        // invalid func
        push(ev(2'd3, 8'h00, 6'd0), "err_event");
        go(3'd7);
        chk("err_pulse", 16'({bus.err, bus.busy, bus.WE}), 16'b100);
        step();
        chk("err_clear", 16'({bus.err, bus.busy}), 16'd0);
        // start with invalid func during busy is ignored
        load(8'h05);
        bus.C_in = 1'b0;
        push(ev(2'd1, 8'h05, 6'd0), "busy_dummy");
        push(ev(2'd1, 8'h06, 6'b100100), "busy_write");
        push(ev(2'd2, 8'd4, 6'd0), "busy_done");
        go(3'd0);
        bus.start = 1'b1;
        bus.func  = 3'd7;
        step();
        step();
        bus.start = 1'b0;
        bus.func  = 3'd0;
        wait_idle("busy");
        // reset in the middle of WRITE
        load(8'h20);
        push(ev(2'd1, 8'h20, 6'd0), "rst_dummy");
        go(3'd1);
        step();
        step();
        chk("pre_reset_we", 16'(bus.WE), 16'd1);
        reset = 1'b1;
        #1;
        chk("reset_mid", 16'({bus.WE, bus.nz_we, bus.c_we, bus.busy, bus.done, bus.err}), 16'd0);
        step();
        reset = 1'b0;
        repeat (3) step();
        chk("no_restart", 16'(bus.busy), 16'd0);
        run(3'd0, 8'h20, 1'b0, ev(2'd1, 8'h21, 6'b100100), "post_rst");
        repeat (2) step();
        chk("queue_empty", 16'(q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
